// File: rtl/alu_pkg.sv
// alu_pkg: shared types and constants for the multi-cycle ALU.
//   alu_op_t  - 3-bit operation encoding on the op input
//   state_t   - controller states
//   FLAG_*    - bit positions of N, Z, C, V in ALUFlags
package alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD  = 3'b000,
    OP_SUB  = 3'b001,
    OP_AND  = 3'b010,
    OP_ORR  = 3'b011,
    OP_EOR  = 3'b100,
    OP_ADC  = 3'b101,
    OP_MUL  = 3'b110,
    OP_UDIV = 3'b111
  } alu_op_t;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

endpackage

// File: rtl/alu_mc_if.sv
// alu_mc_if: request/response bundle of the multi-cycle ALU.
//   master (requester): drives start, op, setflags, a, b;
//                       observes ready, done, Result, ALUFlags
//   slave  (alu_mc):    the mirror image
interface alu_mc_if #(
  parameter int N = 32
);
  logic         start;
  logic [2:0]   op;
  logic         setflags;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         ready;
  logic         done;
  logic [N-1:0] Result;
  logic [3:0]   ALUFlags;

  modport master (
    output start, op, setflags, a, b,
    input  ready, done, Result, ALUFlags
  );

  modport slave (
    input  start, op, setflags, a, b,
    output ready, done, Result, ALUFlags
  );
endinterface

// File: rtl/alu_mc_iter.sv
// alu_mc_iter: N-iteration shift-add multiplier / restoring divider that
// share one N+1-bit adder.
//   clk, reset : clock, asynchronous active-high reset
//   load       : capture operands and clear the iteration count
//   mode       : 0 = MUL (low N bits of a*b), 1 = UDIV (a/b, 0 when b=0)
//   a, b       : operands, used only on load
//   cnt_done   : the iteration performed on the coming edge is the N-th
//   result     : value the datapath holds after the coming iteration
// Iterates on every edge after load; the controller only samples result
// on the edge where cnt_done is high.
module alu_mc_iter #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         mode,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         cnt_done,
  output logic [N-1:0] result
);
  localparam int CW = $clog2(N);

  // x: accumulator (MUL) / partial remainder (UDIV)
  // y: shifting multiplicand (MUL) / divisor (UDIV)
  // z: shifting multiplier (MUL) / dividend shifting out, quotient in (UDIV)
  logic [CW-1:0] cnt_q;
  logic [N-1:0]  x_q, y_q, z_q;
  logic [N-1:0]  x_d, y_d, z_d;
  logic          mode_q;

  logic [N:0]    rem_sh;
  logic [N:0]    add_a, add_b, add_s;
  logic          add_ci, add_co;
  logic          unused_sum_msb;

  assign {add_co, add_s} = {1'b0, add_a} + {1'b0, add_b} + {{(N+1){1'b0}}, add_ci};
  assign unused_sum_msb  = add_s[N];

  always_comb begin
    rem_sh = {x_q, z_q[N-1]};
    add_a  = '0;
    add_b  = '0;
    add_ci = 1'b0;
    x_d    = x_q;
    y_d    = y_q;
    z_d    = z_q;
    if (mode_q) begin
      // trial subtract; carry out means shifted remainder >= divisor
      add_a  = rem_sh;
      add_b  = ~{1'b0, y_q};
      add_ci = 1'b1;
      x_d    = add_co ? add_s[N-1:0] : rem_sh[N-1:0];
      z_d    = {z_q[N-2:0], add_co};
    end else begin
      add_a  = {1'b0, x_q};
      add_b  = z_q[0] ? {1'b0, y_q} : '0;
      x_d    = add_s[N-1:0];
      y_d    = {y_q[N-2:0], 1'b0};
      z_d    = {1'b0, z_q[N-1:1]};
    end
    if (mode_q) result = (y_q == '0) ? '0 : z_d;
    else        result = x_d;
  end

  assign cnt_done = (cnt_q == CW'(N - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q  <= '0;
      x_q    <= '0;
      y_q    <= '0;
      z_q    <= '0;
      mode_q <= 1'b0;
    end else if (load) begin
      cnt_q  <= '0;
      x_q    <= '0;
      y_q    <= b;
      z_q    <= a;
      mode_q <= mode;
    end else begin
      cnt_q  <= cnt_q + CW'(1);
      x_q    <= x_d;
      y_q    <= y_d;
      z_q    <= z_d;
    end
  end
endmodule

// File: rtl/alu_mc.sv
// alu_mc: multi-cycle ALU with registered Result and NZCV flag file.
//   clk, reset : clock, asynchronous active-high reset
//   bus        : alu_mc_if.slave - start/op/setflags/a/b in,
//                ready/done/Result/ALUFlags out (all outputs registered)
// Single-cycle ops complete on the accept edge; MUL/UDIV run N iterations
// in alu_mc_iter and complete on the N-th iteration edge.
module alu_mc
  import alu_pkg::*;
#(
  parameter int N = 32
) (
  input  logic       clk,
  input  logic       reset,
  alu_mc_if.slave    bus
);
  state_t       state_q;
  logic [N-1:0] result_q;
  logic [3:0]   flags_q;
  logic         done_q, ready_q, sf_q;

  alu_op_t      op;
  logic         accept, is_iter;
  logic [N-1:0] b_eff, sc_res, iter_res;
  logic [N:0]   sum;
  logic         cin;
  logic [3:0]   sc_flags;
  logic         iter_done;

  assign op      = alu_op_t'(bus.op);
  assign accept  = bus.start && ready_q;
  assign is_iter = (op == OP_MUL) || (op == OP_UDIV);

  // single-cycle datapath; ADC carry-in is the registered C flag
  always_comb begin
    b_eff    = (op == OP_SUB) ? ~bus.b : bus.b;
    cin      = (op == OP_SUB) ? 1'b1 : ((op == OP_ADC) ? flags_q[FLAG_C] : 1'b0);
    sum      = {1'b0, bus.a} + {1'b0, b_eff} + {{N{1'b0}}, cin};
    sc_res   = sum[N-1:0];
    case (op)
      OP_AND:  sc_res = bus.a & bus.b;
      OP_ORR:  sc_res = bus.a | bus.b;
      OP_EOR:  sc_res = bus.a ^ bus.b;
      default: sc_res = sum[N-1:0];
    endcase
    sc_flags         = flags_q;
    sc_flags[FLAG_N] = sc_res[N-1];
    sc_flags[FLAG_Z] = (sc_res == '0);
    if (op == OP_ADD || op == OP_SUB || op == OP_ADC) begin
      sc_flags[FLAG_C] = sum[N];
      sc_flags[FLAG_V] = (bus.a[N-1] == b_eff[N-1]) && (sum[N-1] != bus.a[N-1]);
    end
  end

  alu_mc_iter #(.N(N)) u_iter (
    .clk      (clk),
    .reset    (reset),
    .load     (accept && is_iter),
    .mode     (op == OP_UDIV),
    .a        (bus.a),
    .b        (bus.b),
    .cnt_done (iter_done),
    .result   (iter_res)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      result_q <= '0;
      flags_q  <= '0;
      done_q   <= 1'b0;
      ready_q  <= 1'b1;
      sf_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
          if (accept) begin
            sf_q <= bus.setflags;
            if (is_iter) begin
              state_q <= BUSY;
              ready_q <= 1'b0;
            end else begin
              result_q <= sc_res;
              if (bus.setflags) flags_q <= sc_flags;
              done_q   <= 1'b1;
              state_q  <= DONE;
            end
          end
        end
        BUSY: begin
          if (iter_done) begin
            result_q <= iter_res;
            if (sf_q) flags_q <= {iter_res[N-1], iter_res == '0, flags_q[FLAG_C], flags_q[FLAG_V]};
            done_q   <= 1'b1;
            ready_q  <= 1'b1;
            state_q  <= DONE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.ready    = ready_q;
  assign bus.done     = done_q;
  assign bus.Result   = result_q;
  assign bus.ALUFlags = flags_q;
endmodule

// File: tb/tb_alu_mc.sv
module tb_alu_mc;
  localparam int N = 32;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  alu_mc_if #(.N(N)) bus ();
  alu_mc #(.N(N)) dut (.clk(clk), .reset(reset), .bus(bus));

  int passed = 0, total = 0, failed = 0;
  logic [N-1:0] m_res;
  logic [3:0]   m_flags;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // reference model: plain integer arithmetic on the architectural rules
  task automatic model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input logic sf);
    longint unsigned ua, ub, full;
    longint sa, sb, sfull;
    logic [31:0] r;
    logic c, v;
    ua = a; ub = b; sa = $signed(a); sb = $signed(b);
    c = m_flags[1]; v = m_flags[0];
    full = 0; sfull = 0;
    case (op)
      3'd0: begin full = ua + ub; sfull = sa + sb; end
      3'd1: begin full = ua - ub; sfull = sa - sb; end
      3'd5: begin full = ua + ub + m_flags[1]; sfull = sa + sb + longint'(m_flags[1]); end
      default: ;
    endcase
    case (op)
      3'd0, 3'd5: begin r = full[31:0]; c = full[32]; end
      3'd1:       begin r = full[31:0]; c = (ua >= ub); end
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: r = a ^ b;
      3'd6: begin full = ua * ub; r = full[31:0]; end
      default: r = (b == 0) ? 32'd0 : a / b;
    endcase
    if (op == 3'd0 || op == 3'd1 || op == 3'd5)
      v = (sfull > 64'sd2147483647) || (sfull < -64'sd2147483648);
    m_res = r;
    if (sf) m_flags = {r[31], r == 0, c, v};
  endtask

  // entered and left just after a falling edge
  task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic sf, input string tag);
    int lat;
    chk({tag, " ready_at_issue"}, bus.ready, 1);
    bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b; bus.setflags = sf;
    model(op, a, b, sf);
    @(negedge clk);
    bus.start = 1'b0;
    lat = 1;
    while (bus.done !== 1'b1 && lat < 3 * N) begin
      chk({tag, " ready_busy"}, bus.ready, 0);
      @(negedge clk);
      lat++;
    end
    chk({tag, " latency"}, lat, (op >= 3'd6) ? N + 1 : 1);
    chk({tag, " result"}, bus.Result, m_res);
    chk({tag, " flags"}, bus.ALUFlags, m_flags);
  endtask

  initial begin
    logic [2:0]  rop;
    logic [31:0] ra, rb;
    int lat;
    reset = 1'b1;
    bus.start = 1'b0; bus.op = '0; bus.a = '0; bus.b = '0; bus.setflags = 1'b0;
    m_flags = '0; m_res = '0;
    #1;
    chk("rst ready", bus.ready, 1);
    chk("rst done", bus.done, 0);
    chk("rst result", bus.Result, 0);
    chk("rst flags", bus.ALUFlags, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    do_op(3'd0, 32'h7FFF_FFFF, 32'd1, 1'b1, "add_ovf");
    chk("add_ovf const_res", bus.Result, 32'h8000_0000);
    chk("add_ovf const_nzcv", bus.ALUFlags, 4'b1001);

    do_op(3'd1, 32'd5, 32'd5, 1'b1, "sub_eq");
    chk("sub_eq const_nzcv", bus.ALUFlags, 4'b0110);
    do_op(3'd2, 32'hF0, 32'h0F, 1'b1, "and_b2b");
    chk("and_b2b const_nzcv", bus.ALUFlags, 4'b0110);

    do_op(3'd6, 32'hFFFF_FFFF, 32'd3, 1'b0, "mul");
    chk("mul const_res", bus.Result, 32'hFFFF_FFFD);
    do_op(3'd7, 32'd100, 32'd7, 1'b1, "udiv");
    chk("udiv const_res", bus.Result, 32'd14);
    do_op(3'd7, 32'd100, 32'd0, 1'b1, "udiv0");
    chk("udiv0 const_z", bus.ALUFlags[2], 1'b1);
    do_op(3'd1, 32'hFFFF_FFFF, 32'd0, 1'b1, "sub_c");
    do_op(3'd5, 32'd1, 32'd1, 1'b1, "adc");
    chk("adc const_res", bus.Result, 32'd3);
    @(negedge clk);
    chk("idle done_low", bus.done, 0);

    // start held high with another op during BUSY must be ignored
    do_op(3'd7, 32'hDEAD_BEEF, 32'd1234, 1'b1, "udiv_hold");
    bus.start = 1'b1; bus.op = 3'd7; bus.a = 32'd999; bus.b = 32'd3; bus.setflags = 1'b0;
    model(3'd7, 32'd999, 32'd3, 1'b0);
    @(negedge clk);
    bus.op = 3'd0; bus.a = 32'd1; bus.b = 32'd1; bus.setflags = 1'b1;
    lat = 1;
    while (bus.done !== 1'b1 && lat < 3 * N) begin
      if (lat == 20) bus.start = 1'b0;
      @(negedge clk);
      lat++;
    end
    bus.start = 1'b0;
    chk("busy_ignore latency", lat, N + 1);
    chk("busy_ignore result", bus.Result, m_res);
    chk("busy_ignore flags", bus.ALUFlags, m_flags);
    @(negedge clk);
    chk("busy_ignore no_extra_done", bus.done, 0);

    // asynchronous reset in the middle of a UDIV
    bus.start = 1'b1; bus.op = 3'd7; bus.a = $urandom; bus.b = 32'd3; bus.setflags = 1'b1;
    @(negedge clk);
    bus.op = 3'd0;
    for (int i = 1; i < 10; i++) begin
      chk("rst_mid busy_done", bus.done, 0);
      @(negedge clk);
    end
    bus.start = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("rst_mid ready", bus.ready, 1);
    chk("rst_mid done", bus.done, 0);
    chk("rst_mid result", bus.Result, 0);
    chk("rst_mid flags", bus.ALUFlags, 0);
    m_flags = '0; m_res = '0;
    @(negedge clk);
    reset = 1'b0;
    lat = 0;
    for (int i = 0; i < N + 8; i++) begin
      @(negedge clk);
      if (bus.done !== 1'b0) lat++;
    end
    chk("rst_mid no_done_after", lat, 0);

    for (int i = 0; i < 40; i++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = $urandom;
      case ($urandom_range(0, 3))
        0:       rb = 32'd0;
        1:       rb = 32'($urandom_range(1, 1000));
        default: rb = $urandom;
      endcase
      do_op(rop, ra, rb, 1'($urandom_range(0, 1)), $sformatf("rnd%0d_op%0d", i, rop));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
